// File: rtl/wb_stage.sv
// Writeback stage: merges execute results and in-order load responses onto the regfile write port.
// Optional performance counters are enabled by defining WB_PERF_EN.
module wb_stage #(
    parameter int LDQ_DEPTH = 2,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ld_issue_valid,
    output logic            ld_issue_ready,
    input  logic [4:0]      ld_issue_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            write,
    output logic [4:0]      writeReg,
    output logic [XLEN-1:0] writeData,
    output logic [31:0]     pending_mask,
    output logic            rsp_err
`ifdef WB_PERF_EN
    ,
    output logic [31:0]     perf_wr_cnt,
    output logic [31:0]     perf_coll_cnt
`endif
);

    localparam int PW = $clog2(LDQ_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [4:0]           ldq_rd_q  [LDQ_DEPTH];
    logic [2:0]           ldq_f3_q  [LDQ_DEPTH];
    logic [1:0]           ldq_lo_q  [LDQ_DEPTH];
    logic [LDQ_DEPTH-1:0] ldq_vld_q, ldq_vld_d;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;

    logic                 skid_vld_q;
    logic [4:0]           skid_rd_q;
    logic [XLEN-1:0]      skid_data_q;

    logic                 write_q, write_d;
    logic [4:0]           wreg_q, wreg_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;
    logic                 rsp_err_q;

    logic ldq_full, ldq_empty;
    logic ld_push, ld_pop, ex_xfer, skid_fill, skid_drain;
    logic [XLEN-1:0] ld_data, rsp_shift;
    logic [7:0]      rsp_byte;
    logic [15:0]     rsp_half;
    logic [4:0]      head_rd;
    logic [2:0]      head_f3;
    logic [1:0]      head_lo;

    // Circular FIFO: the slot under wr_ptr is occupied only when full, the slot under rd_ptr only when non-empty.
    assign ldq_full  = ldq_vld_q[wr_ptr_q];
    assign ldq_empty = !ldq_vld_q[rd_ptr_q];

    assign ex_ready       = !skid_vld_q;
    assign ld_issue_ready = !ldq_full;

    assign ld_push    = ld_issue_valid && !ldq_full;
    assign ld_pop     = mem_rsp_valid && !ldq_empty;
    assign ex_xfer    = ex_valid && ex_ready;
    assign skid_fill  = ex_xfer && ld_pop;
    assign skid_drain = skid_vld_q && !ld_pop;

    assign head_rd = ldq_rd_q[rd_ptr_q];
    assign head_f3 = ldq_f3_q[rd_ptr_q];
    assign head_lo = ldq_lo_q[rd_ptr_q];

    assign rsp_shift = mem_rsp_data >> {head_lo, 3'b000};
    assign rsp_byte  = rsp_shift[7:0];
    assign rsp_half  = head_lo[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

    always_comb begin
        ld_data = mem_rsp_data;
        case (head_f3)
            3'b000:  ld_data = {{(XLEN-8){rsp_byte[7]}}, rsp_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, rsp_byte};
            3'b001:  ld_data = {{(XLEN-16){rsp_half[15]}}, rsp_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, rsp_half};
            default: ld_data = mem_rsp_data;
        endcase
    end

    always_comb begin
        ldq_vld_d = ldq_vld_q;
        if (ld_push) ldq_vld_d[wr_ptr_q] = 1'b1;
        if (ld_pop)  ldq_vld_d[rd_ptr_q] = 1'b0;
    end

    // Priority: load response, then skid entry, then a fresh execute transfer.
    always_comb begin
        write_d = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (ld_pop) begin
            if (head_rd != 5'd0) begin
                write_d = 1'b1;
                wreg_d  = head_rd;
                wdata_d = ld_data;
            end
        end else if (skid_vld_q) begin
            if (skid_rd_q != 5'd0) begin
                write_d = 1'b1;
                wreg_d  = skid_rd_q;
                wdata_d = skid_data_q;
            end
        end else if (ex_xfer) begin
            if (ex_rd != 5'd0) begin
                write_d = 1'b1;
                wreg_d  = ex_rd;
                wdata_d = ex_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ldq_vld_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            skid_vld_q  <= 1'b0;
            skid_rd_q   <= '0;
            skid_data_q <= '0;
            write_q     <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ldq_vld_q <= ldq_vld_d;
            if (ld_push) begin
                ldq_rd_q[wr_ptr_q] <= ld_issue_rd;
                ldq_f3_q[wr_ptr_q] <= ld_funct3;
                ldq_lo_q[wr_ptr_q] <= ld_addr_lo;
                wr_ptr_q           <= wr_ptr_q + PTR_ONE;
            end
            if (ld_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (skid_fill) begin
                skid_vld_q  <= 1'b1;
                skid_rd_q   <= ex_rd;
                skid_data_q <= ex_result;
            end else if (skid_drain) begin
                skid_vld_q <= 1'b0;
            end
            write_q <= write_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            if (mem_rsp_valid && ldq_empty) rsp_err_q <= 1'b1;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (ldq_vld_q[i]) pending_mask[ldq_rd_q[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    assign write     = write_q;
    assign writeReg  = wreg_q;
    assign writeData = wdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef WB_PERF_EN
    logic [31:0] perf_wr_q, perf_coll_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wr_q   <= '0;
            perf_coll_q <= '0;
        end else begin
            if (write_q)   perf_wr_q   <= perf_wr_q + 32'd1;
            if (skid_fill) perf_coll_q <= perf_coll_q + 32'd1;
        end
    end

    assign perf_wr_cnt   = perf_wr_q;
    assign perf_coll_cnt = perf_coll_q;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the register file.
- Merges single-cycle execute results with variable-latency load responses into the regfile's single write port (write / writeReg / writeData).
- Tracks outstanding loads in order, aligns and sign- or zero-extends load data, and exports a pending-register mask for the hazard unit.

Parameters:
- LDQ_DEPTH, 2, number of outstanding loads tracked (power of two, ≥2).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  stage can accept an execute result.
- ex_rd  in  5  execute destination register.
- ex_result  in  XLEN  execute result.
- ld_issue_valid  in  1  load issued to memory.
- ld_issue_ready  out  1  load queue has space.
- ld_issue_rd  in  5  load destination.
- ld_funct3  in  3  load type (RV32I encoding).
- ld_addr_lo  in  2  byte offset of load address.
- mem_rsp_valid  in  1  memory load data valid, single-cycle pulse, cannot be stalled.
- mem_rsp_data  in  XLEN  raw aligned word from memory.
- write  out  1  regfile write enable.
- writeReg  out  5  regfile write address.
- writeData  out  XLEN  regfile write data.
- pending_mask  out  32  bit i set: a queued load targets xi; bit 0 always 0.
- rsp_err  out  1  sticky: a response arrived with an empty load queue.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high (fixed).
- Reset values:
  - write=0, writeReg=0, writeData=0, rsp_err=0, pending_mask=0.
  - Load queue empty; skid buffer empty.
- Handshakes:
  - ex_ready = !skid_valid (combinational). It is 1 in the first cycle after reset.
  - ld_issue_ready = !ldq_full. A push while full is not permitted, even with a simultaneous pop.
  - A transfer occurs when valid & ready are both high at the rising edge.
- Load queue:
  - In-order FIFO of {rd, funct3, addr_lo}.
  - Pushed on an issue transfer; popped on mem_rsp_valid when non-empty.
  - Push and pop in the same cycle are allowed when not full.
- Output register, one cycle of latency. Each cycle selects at most one source, in this priority order:
  1. Load response (queue non-empty).
  2. Skid entry.
  3. New execute transfer.
- If the selected source's rd=0, then write=0 the next cycle; the entry is still consumed.
- Otherwise, next cycle: write=1, writeReg=rd, writeData=the result.
- If no source is selected, write=0; writeReg and writeData hold their previous values.
- Collisions:
  - An execute transfer that loses arbitration goes into the skid buffer, so ex_ready drops the next cycle.
  - The skid drains on the first cycle with no load response.
  - The skid cannot be filled while already full, because ex_ready=0 then.
- Load alignment (data = mem_rsp_data):
  - 000 LB: byte[addr_lo], sign-extended.
  - 100 LBU: byte[addr_lo], zero-extended.
  - 001 LH: half[addr_lo[1]], sign-extended.
  - 101 LHU: half[addr_lo[1]], zero-extended.
  - 010 LW and any other encoding: full word. addr_lo is ignored for halves (bit 0) and for words.
- mem_rsp_valid with an empty queue:
  - Response is dropped, no write.
  - rsp_err is set and stays set until rst.
- pending_mask:
  - Combinational OR of one-hot(rd) over valid queue entries; x0 is excluded.
  - Updates in the same cycle as push/pop state.
- Ordering: the hazard unit must not issue an execute op whose rd or sources are in pending_mask. The stage does not check for WAW.
- rst mid-operation: queue, skid and outputs are cleared on that edge. Responses to loads issued before reset are reported as rsp_err if they arrive while the queue is empty.

Optional Feature:
- Macro WB_PERF_EN.
- When defined, adds:
  - Output perf_wr_cnt[31:0]: increments on every cycle with write=1.
  - Output perf_coll_cnt[31:0]: increments on every execute transfer that enters the skid buffer.
  - Both counters wrap modulo 2^32 and reset to 0 on rst.
- When not defined, the ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then ex transfer rd=5, result=0x1234_5678 → next cycle write=1, writeReg=5, writeData=0x12345678; the cycle after, write=0.
- Issue LB rd=7, addr_lo=3, then response 0x80AB_CDEF → pending_mask=0x80 while queued; then write=1, writeReg=7, writeData=0xFFFF_FF80, pending_mask=0.
- Issue LHU rd=9, addr_lo=2, response 0xBEEF_0001 → writeData=0x0000_BEEF.
- Load response and ex transfer (rd=3, 0xAA) in the same cycle → load written at N+1, ex_ready=0 at N+1, ex written at N+2, ex_ready=1 at N+2.
- Two loads issued (ld_issue_ready drops to 0), then two responses back-to-back → in-order writes to the correct rds; a third response arrives with the queue empty → no write, rsp_err=1 and held.
- ex transfer rd=0 → write stays 0. Assert rst while the queue holds 1 load and the skid is full → next cycle write=0, pending_mask=0, ex_ready=1, ld_issue_ready=1.
